// File: rtl/serial_tx_pkg.sv
// serial_tx shared definitions: frame state encodings and line levels.
// Encodings are shared with the future receiver; guarded by SERIAL_DEFS.
`ifndef SERIAL_DEFS
`define SERIAL_DEFS

package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

`endif

// File: rtl/serial_tx_tick_gen.sv
// serial_tick_gen: bit-period divider for serial_tx.
// TICK marks the last clock of each DIV-cycle bit period.
module serial_tick_gen #(
    parameter int DIV = 4
) (
    input  logic C,
    input  logic R,
    input  logic CLR,
    output logic TICK
);

    logic [7:0] cnt;

    assign TICK = (cnt == 8'(DIV - 1));

    // Count 0..DIV-1, wrapping at the bit end; held at 0 when DIV=1.
    always_ff @(posedge C) begin
        if (R || CLR || TICK) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: valid/ready parallel-to-serial frame transmitter.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before STOP.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             SDO,
    output logic             BUSY
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [BW-1:0]    bitidx;
    logic [BW-1:0]    bitidx_n;
    logic             tick;
    logic             clr;
    logic             sdo_n;
`ifdef SERIAL_TX_PARITY_EN
    logic             par;
    logic             par_n;
`endif

    serial_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .C    (C),
        .R    (R),
        .CLR  (clr),
        .TICK (tick)
    );

    // Next state, shift/bit bookkeeping and the next SDO level.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitidx_n = bitidx;
        clr      = 1'b0;
        sdo_n    = IDLE_LVL;
`ifdef SERIAL_TX_PARITY_EN
        par_n    = par;
`endif
        unique case (state)
            ST_IDLE: begin
                clr = 1'b1;
                if (VALID) begin
                    state_n  = ST_START;
                    shreg_n  = DATA;
                    bitidx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n    = ^DATA;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bitidx == LAST) begin
                        bitidx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n  = ST_PARITY;
`else
                        state_n  = ST_STOP;
`endif
                    end else begin
                        bitidx_n = bitidx + BW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_START:  sdo_n = START_LVL;
            ST_DATA:   sdo_n = shreg_n[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: sdo_n = par_n;
`endif
            default:   sdo_n = IDLE_LVL;
        endcase
    end

    // Frame state and registered line/handshake outputs; R wins.
    always_ff @(posedge C) begin
        if (R) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitidx <= '0;
            SDO    <= IDLE_LVL;
            READY  <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitidx <= bitidx_n;
            SDO    <= sdo_n;
            READY  <= (state_n == ST_IDLE);
            BUSY   <= (state_n != ST_IDLE);
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the latched word, captured at the accept edge.
    always_ff @(posedge C) begin
        if (R) begin
            par <= 1'b0;
        end else begin
            par <= par_n;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx.
// Two instances: default 8-bit/DIV=4 and 4-bit/DIV=1.
module tb_serial_tx;

    localparam int W0 = 8;
    localparam int D0 = 4;
    localparam int W1 = 4;
    localparam int D1 = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LEN0 = D0 * (W0 + 2 + PB);
    localparam int LEN1 = D1 * (W1 + 2 + PB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          r0;
    logic [W0-1:0] data0;
    logic          valid0;
    logic          ready0;
    logic          sdo0;
    logic          busy0;

    logic          r1;
    logic [W1-1:0] data1;
    logic          valid1;
    logic          ready1;
    logic          sdo1;
    logic          busy1;

    serial_tx #(.WIDTH(W0), .DIV(D0)) u0 (
        .C     (clk),
        .R     (r0),
        .DATA  (data0),
        .VALID (valid0),
        .READY (ready0),
        .SDO   (sdo0),
        .BUSY  (busy0)
    );

    serial_tx #(.WIDTH(W1), .DIV(D1)) u1 (
        .C     (clk),
        .R     (r1),
        .DATA  (data1),
        .VALID (valid1),
        .READY (ready1),
        .SDO   (sdo1),
        .BUSY  (busy1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];
    logic cap_sdo[$];
    logic cap_rdy[$];
    logic cap_busy[$];

    // Expected line level per cycle after the accept edge.
    function automatic void model(input logic [15:0] d, input int w,
                                  input int div, input bit clear);
        bit p;
        p = 1'b0;
        if (clear) exp_q.delete();
        repeat (div) exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            repeat (div) exp_q.push_back(d[i]);
            p ^= d[i];
        end
`ifdef SERIAL_TX_PARITY_EN
        repeat (div) exp_q.push_back(p);
`endif
        repeat (div) exp_q.push_back(1'b1);
    endfunction

    // Record n samples, the first at the current time (#1 after an edge).
    task automatic cap(input int dut, input int n);
        cap_sdo.delete();
        cap_rdy.delete();
        cap_busy.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (dut == 0) begin
                cap_sdo.push_back(sdo0);
                cap_rdy.push_back(ready0);
                cap_busy.push_back(busy0);
            end else begin
                cap_sdo.push_back(sdo1);
                cap_rdy.push_back(ready1);
                cap_busy.push_back(busy1);
            end
        end
    endtask

    task automatic test_reset();
        r0 = 1'b1; r1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sdo0, ready0, busy0} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_u0 got %b want 110", {sdo0, ready0, busy0});
        end
        n_checks++;
        if ({sdo1, ready1, busy1} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_u1 got %b want 110", {sdo1, ready1, busy1});
        end
        @(negedge clk);
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({sdo0, ready0, busy0} !== 3'b110) begin
                n_fail++;
                $display("FAIL idle_u0 cyc %0d got %b want 110",
                         i, {sdo0, ready0, busy0});
            end
        end
    endtask

    task automatic test_frame(input logic [W0-1:0] d);
        @(negedge clk);
        data0  = d;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        data0  = ~d;
        cap(0, LEN0 + 1);
        model({8'h00, d}, W0, D0, 1'b1);
        for (int i = 0; i < LEN0; i++) begin
            n_checks++;
            if (cap_sdo[i] !== exp_q[i] || cap_rdy[i] !== 1'b0 ||
                cap_busy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL frame %h cyc %0d sdo/rdy/busy %b%b%b want %b01",
                         d, i, cap_sdo[i], cap_rdy[i], cap_busy[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({cap_sdo[LEN0], cap_rdy[LEN0], cap_busy[LEN0]} !== 3'b110) begin
            n_fail++;
            $display("FAIL frame_end %h got %b%b%b want 110", d,
                     cap_sdo[LEN0], cap_rdy[LEN0], cap_busy[LEN0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 2 * LEN0 + 2;
        @(negedge clk);
        data0  = 8'h3C;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        data0 = 8'hC3;
        cap(0, n);
        valid0 = 1'b0;
        model(16'h003C, W0, D0, 1'b1);
        exp_q.push_back(1'b1);
        model(16'h00C3, W0, D0, 1'b0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (cap_sdo[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_sdo cyc %0d got %b want %b",
                         i, cap_sdo[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({cap_rdy[LEN0], cap_rdy[LEN0+1], cap_rdy[n-1]} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_spacing ready got %b%b%b want 101",
                     cap_rdy[LEN0], cap_rdy[LEN0+1], cap_rdy[n-1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W0-1:0] d;
        d = W0'($urandom);
        @(negedge clk);
        data0  = d;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        cap(0, 15);
        model({8'h00, d}, W0, D0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (cap_sdo[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d got %b want %b",
                         i, cap_sdo[i], exp_q[i]);
            end
        end
        @(negedge clk);
        r0 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sdo0, ready0, busy0} !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_reset got %b want 110", {sdo0, ready0, busy0});
        end
        @(negedge clk);
        r0 = 1'b0;
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [W0-1:0] words [2];
        logic          pexp  [2];
        words[0] = 8'h07; pexp[0] = 1'b1;
        words[1] = 8'h03; pexp[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            data0  = words[k];
            valid0 = 1'b1;
            @(posedge clk);
            #1;
            valid0 = 1'b0;
            cap(0, 45);
            for (int i = D0 * (W0 + 1); i < D0 * (W0 + 2); i++) begin
                n_checks++;
                if (cap_sdo[i] !== pexp[k]) begin
                    n_fail++;
                    $display("FAIL parity %h cyc %0d got %b want %b",
                             words[k], i, cap_sdo[i], pexp[k]);
                end
            end
            n_checks++;
            if ({cap_rdy[43], cap_rdy[44]} !== 2'b01) begin
                n_fail++;
                $display("FAIL parity_len %h ready got %b%b want 01",
                         words[k], cap_rdy[43], cap_rdy[44]);
            end
        end
    endtask
`endif

    task automatic test_div1(input logic [W1-1:0] d);
        @(negedge clk);
        data1  = d;
        valid1 = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        data1  = ~d;
        cap(1, LEN1 + 1);
        model({12'h000, d}, W1, D1, 1'b1);
        for (int i = 0; i < LEN1; i++) begin
            n_checks++;
            if (cap_sdo[i] !== exp_q[i] || cap_rdy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL div1 %h cyc %0d sdo/rdy %b%b want %b0",
                         d, i, cap_sdo[i], cap_rdy[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({cap_sdo[LEN1], cap_rdy[LEN1], cap_busy[LEN1]} !== 3'b110) begin
            n_fail++;
            $display("FAIL div1_end %h got %b%b%b want 110", d,
                     cap_sdo[LEN1], cap_rdy[LEN1], cap_busy[LEN1]);
        end
        if (d == 4'hF) begin
            n_checks++;
            if ({cap_sdo[0], cap_sdo[1], cap_sdo[2], cap_sdo[3], cap_sdo[4]}
                    !== 5'b01111) begin
                n_fail++;
                $display("FAIL div1_F got %b%b%b%b%b want 01111",
                         cap_sdo[0], cap_sdo[1], cap_sdo[2],
                         cap_sdo[3], cap_sdo[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        for (int k = 0; k < 4; k++) begin
            test_frame(W0'($urandom));
        end
        test_back_to_back();
        test_reset_mid_frame();
        test_frame(8'h01);
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_div1(4'hF);
        for (int k = 0; k < 4; k++) begin
            test_div1(W1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
